// File: rtl/alu_opfetch.sv
// Operand-fetch / writeback stage around a combinational RV32I integer ALU.
// Decodes OP and OP-IMM instructions, reads an internal register file,
// forwards the in-flight ALU result, and writes that result back one cycle later.
module alu_opfetch #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [31:0]     inst,
  input  logic            hold,
  output logic [XLEN-1:0] aluin1,
  output logic [XLEN-1:0] aluin2,
  output logic [2:0]      funct3,
  input  logic [XLEN-1:0] aluout,
  output logic            ex_valid,
  output logic [4:0]      ex_rd,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int unsigned NREGS   = 32;
  localparam int unsigned IMM_W   = 12;
  localparam logic [6:0]  OPC_OP  = 7'b0110011;
  localparam logic [6:0]  OPC_IMM = 7'b0010011;

  logic [XLEN-1:0] regs_q [NREGS];

  logic [XLEN-1:0] aluin1_q, aluin1_d;
  logic [XLEN-1:0] aluin2_q, aluin2_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      ex_rd_q,  ex_rd_d;
  logic            ex_valid_q, ex_valid_d;
  logic            illegal_q,  illegal_d;
  logic            wr_en;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rs1, rs2, rd;
  logic            is_op, is_imm, legal, accept;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_sext;

  // Instruction field split and handshake
  always_comb begin
    opcode     = inst[6:0];
    rd         = inst[11:7];
    f3         = inst[14:12];
    rs1        = inst[19:15];
    rs2        = inst[24:20];
    f7         = inst[31:25];
    imm_sext   = {{(XLEN-IMM_W){inst[31]}}, inst[31:20]};
    inst_ready = !hold && !rst;
    accept     = inst_valid && inst_ready;
  end

  // Decode legality: only the single-cycle ALU ops without shifts or SUB
  always_comb begin
    is_op  = (opcode == OPC_OP) && (f7 == 7'd0);
    is_imm = (opcode == OPC_IMM);
    legal  = (is_op || is_imm) && (f3 != 3'b001) && (f3 != 3'b101);
  end

  // Operand read with forwarding of the in-flight EX result
  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2];
    if (ex_valid_q && (ex_rd_q != 5'd0) && (rs1 == ex_rd_q)) rs1_val = aluout;
    if (ex_valid_q && (ex_rd_q != 5'd0) && (rs2 == ex_rd_q)) rs2_val = aluout;
  end

  // EX register next state and writeback enable
  always_comb begin
    aluin1_d   = aluin1_q;
    aluin2_d   = aluin2_q;
    funct3_d   = funct3_q;
    ex_rd_d    = ex_rd_q;
    ex_valid_d = ex_valid_q;
    illegal_d  = 1'b0;
    wr_en      = 1'b0;
    if (!hold) begin
      ex_valid_d = 1'b0;
      wr_en      = ex_valid_q && (ex_rd_q != 5'd0);
      if (accept) begin
        aluin1_d   = rs1_val;
        aluin2_d   = is_imm ? imm_sext : rs2_val;
        funct3_d   = f3;
        ex_rd_d    = rd;
        ex_valid_d = legal;
        illegal_d  = !legal;
      end
    end
  end

  // EX register state
  always_ff @(posedge clk) begin
    if (rst) begin
      aluin1_q   <= '0;
      aluin2_q   <= '0;
      funct3_q   <= '0;
      ex_rd_q    <= '0;
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      aluin1_q   <= aluin1_d;
      aluin2_q   <= aluin2_d;
      funct3_q   <= funct3_d;
      ex_rd_q    <= ex_rd_d;
      ex_valid_q <= ex_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  // Register file write port; x0 writes are filtered by wr_en
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[ex_rd_q] <= aluout;
    end
  end

  // Output mapping and debug read port
  always_comb begin
    aluin1   = aluin1_q;
    aluin2   = aluin2_q;
    funct3   = funct3_q;
    ex_rd    = ex_rd_q;
    ex_valid = ex_valid_q;
    illegal  = illegal_q;
    dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];
  end

endmodule

// File: tb/tb_alu_opfetch.sv
// Bench for alu_opfetch: behavioural ALU, in-order architectural model, per-cycle compare.
module tb_alu_opfetch;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            inst_valid = 1'b0;
  logic            inst_ready;
  logic [31:0]     inst = 32'h0;
  logic            hold = 1'b0;
  logic [XLEN-1:0] aluin1, aluin2, aluout;
  logic [2:0]      funct3;
  logic            ex_valid, illegal;
  logic [4:0]      ex_rd;
  logic [4:0]      dbg_addr = 5'd0;
  logic [XLEN-1:0] dbg_data;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  alu_opfetch #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .hold(hold), .aluin1(aluin1), .aluin2(aluin2), .funct3(funct3),
    .aluout(aluout), .ex_valid(ex_valid), .ex_rd(ex_rd), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  assign aluout = alu_f(aluin1, aluin2, funct3);

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), 3'(f3), 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model: m_arch is the in-order result state, m_vis what the register file should show
  logic [31:0] m_arch [32];
  logic [31:0] m_vis  [32];
  logic [31:0] m_a1 = '0, m_a2 = '0, m_res = '0;
  logic [2:0]  m_f3 = '0;
  logic [4:0]  m_rd = '0;
  logic        m_exv = 1'b0, m_ill = 1'b0, m_known = 1'b1;

  always @(posedge clk) begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, b, imm;
    logic        leg;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_arch[i] = '0; m_vis[i] = '0; end
      m_a1 = '0; m_a2 = '0; m_f3 = '0; m_rd = '0;
      m_exv = 1'b0; m_ill = 1'b0; m_known = 1'b1;
    end else if (hold) begin
      m_ill = 1'b0;
    end else begin
      if (m_exv && m_rd != 5'd0) m_vis[m_rd] = m_res;
      m_ill = 1'b0;
      m_exv = 1'b0;
      if (inst_valid) begin
        op  = inst[6:0];
        f3  = inst[14:12];
        leg = ((op == 7'b0110011 && inst[31:25] == 7'd0) || op == 7'b0010011)
              && f3 != 3'd1 && f3 != 3'd5;
        if (leg) begin
          a   = (inst[19:15] == 5'd0) ? 32'd0 : m_arch[inst[19:15]];
          imm = 32'($signed(inst[31:20]));
          b   = (op == 7'b0010011) ? imm
              : ((inst[24:20] == 5'd0) ? 32'd0 : m_arch[inst[24:20]]);
          m_a1 = a; m_a2 = b; m_f3 = f3; m_rd = inst[11:7];
          m_res = alu_f(a, b, f3);
          if (m_rd != 5'd0) m_arch[m_rd] = m_res;
          m_exv = 1'b1; m_known = 1'b1;
        end else begin
          m_ill = 1'b1; m_known = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("inst_ready", 32'(inst_ready), 32'(!hold && !rst));
      chk("ex_valid",   32'(ex_valid),   32'(m_exv));
      chk("illegal",    32'(illegal),    32'(m_ill));
      chk("dbg_data",   dbg_data,        m_vis[dbg_addr]);
      if (m_known) begin
        chk("aluin1", aluin1, m_a1);
        chk("aluin2", aluin2, m_a2);
        chk("funct3", 32'(funct3), 32'(m_f3));
        chk("ex_rd",  32'(ex_rd),  32'(m_rd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    dbg_addr = 5'(cyc);
  endtask

  task automatic reg_is(input int addr, input logic [31:0] exp, input string name);
    dbg_addr = 5'(addr);
    #1;
    chk(name, dbg_data, exp);
  endtask

  task automatic issue(input logic [31:0] w);
    inst = w; inst_valid = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] seq [3];
    logic [31:0] exp2 [3];
    logic [31:0] bad [3];

    // Initial reset
    rst = 1'b1;
    tick(); tick();
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ready", 32'(inst_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Back-to-back forwarding chain
    seq[0] = enc_i(5, 0, 0, 1);   exp2[0] = 32'd5;
    seq[1] = enc_i(-1, 1, 0, 2);  exp2[1] = 32'hFFFF_FFFF;
    seq[2] = enc_r(0, 2, 1, 0, 3); exp2[2] = 32'd4;
    for (int i = 0; i < 3; i++) begin
      issue(seq[i]);
      #1;
      chk("fwd_aluin2", aluin2, exp2[i]);
      if (i > 0) chk("fwd_aluin1", aluin1, 32'd5);
    end
    inst_valid = 1'b0;
    tick(); tick();
    reg_is(1, 32'd5, "x1");
    reg_is(2, 32'd4, "x2");
    reg_is(3, 32'd9, "x3");

    // x0 is never written and always reads zero
    issue(enc_i(7, 0, 0, 0));
    issue(enc_r(0, 0, 0, 0, 4));
    #1;
    chk("x0_aluin1", aluin1, 32'd0);
    inst_valid = 1'b0;
    tick(); tick();
    reg_is(0, 32'd0, "x0");
    reg_is(4, 32'd0, "x4");

    // Illegal encodings: SUB, SLLI, LW
    bad[0] = enc_r(32, 2, 1, 0, 1);
    bad[1] = enc_i(3, 1, 1, 1);
    bad[2] = {12'd0, 5'd0, 3'b010, 5'd1, 7'b0000011};
    for (int i = 0; i < 3; i++) begin
      issue(bad[i]);
      #1;
      chk("ill_pulse", 32'(illegal), 32'd1);
      chk("ill_exv",   32'(ex_valid), 32'd0);
      inst_valid = 1'b0;
      tick();
      #1;
      chk("ill_clear", 32'(illegal), 32'd0);
    end
    reg_is(1, 32'd5, "x1_after_ill");

    // Hold freezes EX and delays writeback; a pending instruction waits too
    issue(enc_i(12'h0F0, 0, 3'b110, 5));
    hold = 1'b1;
    inst = enc_i(1, 0, 0, 9);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", 32'(inst_ready), 32'd0);
      chk("hold_aluin2", aluin2, 32'h0000_00F0);
      reg_is(5, 32'd0, "hold_x5");
      tick();
    end
    hold = 1'b0;
    tick();
    reg_is(5, 32'h0000_00F0, "x5");
    inst_valid = 1'b0;
    tick(); tick();
    reg_is(9, 32'd1, "x9");

    // Logic ops, sign extension, compares
    issue(enc_i(-1, 5, 3'b100, 6));
    issue(enc_i(12'h7FF, 5, 3'b111, 7));
    issue(enc_r(0, 0, 6, 3'b010, 10));
    issue(enc_r(0, 6, 0, 3'b011, 11));
    inst_valid = 1'b0;
    tick(); tick();
    reg_is(6, 32'hFFFF_FF0F, "x6");
    reg_is(7, 32'h0000_00F0, "x7");
    reg_is(10, 32'd1, "x10");
    reg_is(11, 32'd1, "x11");

    // Reset mid-stream with ADDI in EX and hold asserted
    issue(enc_i(12'h055, 0, 0, 8));
    inst_valid = 1'b0;
    rst = 1'b1;
    hold = 1'b1;
    tick(); tick();
    #1;
    chk("mrst_exv", 32'(ex_valid), 32'd0);
    chk("mrst_ill", 32'(illegal), 32'd0);
    chk("mrst_a1", aluin1, 32'd0);
    chk("mrst_a2", aluin2, 32'd0);
    chk("mrst_f3", 32'(funct3), 32'd0);
    chk("mrst_rd", 32'(ex_rd), 32'd0);
    chk("mrst_ready", 32'(inst_ready), 32'd0);
    rst = 1'b0;
    hold = 1'b0;
    tick(); tick();
    for (int r = 1; r < 32; r++) reg_is(r, 32'd0, "mrst_reg");

    tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/alu_opfetch.md
# alu_opfetch

Operand-fetch and writeback stage wrapped around the combinational integer ALU. It accepts one RV32I OP or OP-IMM instruction per cycle and reads operands from an internal 32 x XLEN register file. It drives registered `aluin1`, `aluin2` and `funct3` into the ALU, then writes the ALU result back to `rd` one cycle later. Same-cycle back-to-back dependencies are resolved by forwarding from the ALU output.

## Interface
- `XLEN`, 32, datapath and register width.

- `clk`  in  1  sole clock; everything is updated on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_valid`  in  1  `inst` holds an instruction to accept.
- `inst_ready`  out  1  stage can accept; equals `!hold && !rst`.
- `inst`  in  32  RV32I instruction word.
- `hold`  in  1  downstream freeze: the EX register holds, no writeback, no accept.
- `aluin1`  out  XLEN  registered operand 1 (rs1 value), to the ALU.
- `aluin2`  out  XLEN  registered operand 2 (rs2 value or sign-extended immediate), to the ALU.
- `funct3`  out  3  registered ALU operation select.
- `aluout`  in  XLEN  combinational ALU result for the current `aluin1`/`aluin2`/`funct3`.
- `ex_valid`  out  1  EX register holds a legal instruction.
- `ex_rd`  out  5  destination register of the EX instruction.
- `illegal`  out  1  one-cycle pulse, registered: the accepted instruction was rejected.
- `dbg_addr`  in  5  debug read address.
- `dbg_data`  out  XLEN  combinational register-file read; always 0 for x0.

## Operation
- **Accept:** an instruction is taken at an edge where `inst_valid && inst_ready`.
- **Decode:**
  - opcode `0110011` (OP) with `funct7 = 0`: `aluin2` = rs2 value.
  - opcode `0010011` (OP-IMM): `aluin2` = `inst[31:20]` sign-extended to XLEN.
- **Legal `funct3`:** 000, 010, 011, 100, 110, 111.
- **Illegal instructions:** `funct3` 001 or 101, OP with `funct7 != 0` (includes SUB), and any other opcode.
  - On accept: `illegal` = 1 next cycle, `ex_valid` = 0, no writeback.
  - The `aluin*`/`funct3` registers still load; their value is don't-care.
- **EX register load:** on a legal accept it loads `aluin1`, `aluin2`, `funct3`, `ex_rd` = `inst[11:7]`, and sets `ex_valid` = 1.
- **EX register clear:** at an edge with no accept and `hold` = 0, `ex_valid` goes to 0 and the other EX fields hold their values.
- **Writeback:** at an edge with `ex_valid && !hold && ex_rd != 0`, `regs[ex_rd] <= aluout`. A write to x0 is discarded.
- **Forwarding:** when decoding, for each of rs1 and rs2, if `ex_valid && ex_rd != 0 && rs == ex_rd`, use `aluout` instead of the register file value.
- **Hold:** while `hold` = 1:
  - `inst_ready` = 0 and the EX register and `ex_valid` are frozen.
  - No write is performed and `illegal` = 0.
  - The pending writeback happens at the first edge after `hold` falls.
- **Simultaneous accept and writeback:** both occur at the same edge. Forwarding makes the new operands correct.
- **Reset:** see Timing.

## Timing
- **Reset values** (at the first edge with `rst` = 1):
  - all 32 registers = 0.
  - `ex_valid` = 0, `illegal` = 0, `aluin1` = `aluin2` = 0, `funct3` = 0, `ex_rd` = 0.
  - `inst_ready` = 0 combinationally while `rst` = 1.
- **Reset during operation:** any in-flight EX instruction is discarded without writeback, and `hold` is ignored.
- **Latency:**
  - accept at edge N;
  - operands valid and `ex_valid` = 1 during cycle N+1;
  - result written at edge N+1 (later if `hold` is asserted);
  - the value is visible on `dbg_data` from cycle N+2.
- **Throughput:** 1 instruction per cycle with `hold` = 0 and `inst_valid` = 1, including dependent pairs.
- **Combinational paths:**
  - `aluout` → forwarding mux → EX register inputs.
  - `hold` → `inst_ready`.
- **Read width:** register file reads are asynchronous (combinational).

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-stream with an ADDI in EX -> all outputs 0, `dbg_data` for x1..x31 = 0, and the EX instruction is not written.
- **Back-to-back forwarding:**
  - stream: ADDI x1,x0,5; ADDI x2,x1,-1; ADD x3,x1,x2 (`inst_valid` held 1);
  - the three EX-cycle values `aluin2` are 5, -1 = 0xFFFFFFFF, 4;
  - final register values x1 = 5, x2 = 4, x3 = 9.
- **x0 behaviour:** ADDI x0,x0,7 then ADD x4,x0,x0 -> x0 reads 0, `aluin1` = 0 for the second instruction, x4 = 0.
- **Illegal instructions:** SUB, SLLI, and LW encodings -> `illegal` pulses 1 cycle each, `ex_valid` = 0, and the register file is unchanged.
- **Hold:**
  - ORI x5,x0,0x0F0 accepted, then `hold` = 1 for 3 cycles;
  - during hold: `inst_ready` = 0, x5 still 0, `aluin2` = 0xF0 stable;
  - at the first edge after release: x5 = 0xF0.
- **Logic ops and sign extension:** XORI x6,x5,-1 and ANDI x7,x5,0x7FF -> x6 = 0xFFFFFF0F, x7 = 0xF0.
